// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: operation codes,
// FSM state encoding and a small decode helper.
package usr_pkg;

  localparam logic [2:0] MODE_LOAD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_ROL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ASR  = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Codes 110 and 111 are both no-operation.
  function automatic logic is_nop(input logic [2:0] m);
    return m[2] & m[1];
  endfunction

endpackage

// File: rtl/usr_shift_step.sv
// Combinational single-step next value of the register for a given mode.
// LOAD and NOP leave the value unchanged here; LOAD is handled by the top.
module usr_shift_step
  import usr_pkg::*;
#(
  parameter int DATA_WID = 8
) (
  input  logic [DATA_WID-1:0] cur,
  input  logic [2:0]          mode,
  input  logic                ser_in_lsb,
  input  logic                ser_in_msb,
  output logic [DATA_WID-1:0] nxt
);

  always_comb begin
    // NOTE: assign a default before the case so every path drives nxt and no latch is inferred.
    nxt = cur;
    case (mode)
      MODE_SHL: nxt = {cur[DATA_WID-2:0], ser_in_lsb};
      MODE_SHR: nxt = {ser_in_msb, cur[DATA_WID-1:1]};
      MODE_ROL: nxt = {cur[DATA_WID-2:0], cur[DATA_WID-1]};
      MODE_ROR: nxt = {cur[0], cur[DATA_WID-1:1]};
      MODE_ASR: nxt = {cur[DATA_WID-1], cur[DATA_WID-1:1]};
      default:  nxt = cur;
    endcase
  end

endmodule

// File: rtl/universal_shift_register.sv
// Multi-mode shift/rotate register with start/busy/done handshake.
// Holds the two-state FSM, the step counter and the Out register.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int DATA_WID = 8,
  parameter int CNT_WID  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [2:0]          mode,
  input  logic [CNT_WID-1:0]  amount,
  input  logic [DATA_WID-1:0] load_data,
  input  logic                ser_in_lsb,
  input  logic                ser_in_msb,
  input  logic                abort,
  output logic [DATA_WID-1:0] Out,
  output logic                ser_out_lsb,
  output logic                ser_out_msb,
  output logic                busy,
  output logic                done
);

  state_e              state_q;
  logic [2:0]          mode_q;
  logic [CNT_WID-1:0]  cnt_q;
  logic [DATA_WID-1:0] out_q;
  logic                busy_q;
  logic                done_q;
  logic [DATA_WID-1:0] shift_d;

  // Fill bits come straight from the ports so a stream can be shifted in live.
  usr_shift_step #(.DATA_WID(DATA_WID)) u_step (
    .cur        (out_q),
    .mode       (mode_q),
    .ser_in_lsb (ser_in_lsb),
    .ser_in_msb (ser_in_msb),
    .nxt        (shift_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_LOAD;
      cnt_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (mode == MODE_LOAD) begin
              out_q  <= load_data;
              done_q <= 1'b1;
            end else if (is_nop(mode) || (amount == '0)) begin
              done_q <= 1'b1;
            end else begin
              mode_q  <= mode;
              cnt_q   <= amount;
              busy_q  <= 1'b1;
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          // Abort wins over the final shift; the command ends silently.
          if (abort) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            out_q <= shift_d;
            cnt_q <= cnt_q - CNT_WID'(1);
            if (cnt_q == CNT_WID'(1)) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign Out         = out_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign ser_out_lsb = out_q[0];
  assign ser_out_msb = out_q[DATA_WID-1];

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench: vector table plus hand-written multi-cycle sequences,
// with a scoreboard queue of expected Out values popped on each done pulse.
module tb_universal_shift_register;
  import usr_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [3:0] amount = 4'd0;
  logic [7:0] load_data = 8'd0;
  logic       ser_in_lsb = 1'b0;
  logic       ser_in_msb = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] Out;
  logic       ser_out_lsb, ser_out_msb, busy, done;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  universal_shift_register #(.DATA_WID(8), .CNT_WID(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .amount(amount),
    .load_data(load_data), .ser_in_lsb(ser_in_lsb), .ser_in_msb(ser_in_msb),
    .abort(abort), .Out(Out), .ser_out_lsb(ser_out_lsb),
    .ser_out_msb(ser_out_msb), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("done_without_cmd", {31'd0, done}, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_at_done", {24'd0, Out}, {24'd0, mon_exp});
      end
    end
  end

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic run_cmd(input logic [2:0] m, input logic [3:0] a, input logic [7:0] ld,
                         input logic lsb, input logic msb, input logic ab,
                         input logic [7:0] exp, input int exp_nb);
    int nb = 0;
    int cyc = 0;
    exp_q.push_back(exp);
    mode = m; amount = a; load_data = ld;
    ser_in_lsb = lsb; ser_in_msb = msb; abort = ab; start = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) nb++;
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 40) check("done_timeout", {31'd0, done}, 32'd1);
    check("busy_cycles", nb, exp_nb);
    check("busy_at_done", {31'd0, busy}, 32'd0);
  endtask

  typedef struct {
    logic [7:0] init;
    logic [2:0] mode;
    logic [3:0] amount;
    logic       lsb;
    logic       msb;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[16];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{8'hA5, MODE_SHL,  4'd3,  1'b1, 1'b0, 8'h2F};
    vecs[1]  = '{8'h80, MODE_ASR,  4'd2,  1'b0, 1'b0, 8'hE0};
    vecs[2]  = '{8'h01, MODE_ROR,  4'd1,  1'b0, 1'b0, 8'h80};
    vecs[3]  = '{8'hA5, MODE_ROL,  4'd8,  1'b0, 1'b0, 8'hA5};
    vecs[4]  = '{8'h3C, MODE_SHR,  4'd0,  1'b0, 1'b1, 8'h3C};
    vecs[5]  = '{8'h3C, 3'b110,    4'd5,  1'b1, 1'b1, 8'h3C};
    vecs[6]  = '{8'h81, MODE_SHR,  4'd3,  1'b0, 1'b1, 8'hF0};
    vecs[7]  = '{8'h5A, MODE_SHL,  4'd15, 1'b0, 1'b1, 8'h00};
    vecs[8]  = '{8'h5A, MODE_SHL,  4'd12, 1'b1, 1'b0, 8'hFF};
    vecs[9]  = '{8'h96, MODE_ROL,  4'd11, 1'b1, 1'b1, 8'hB4};
    vecs[10] = '{8'h96, MODE_ROR,  4'd10, 1'b0, 1'b0, 8'hA5};
    vecs[11] = '{8'h7F, MODE_ASR,  4'd15, 1'b1, 1'b1, 8'h00};
    vecs[12] = '{8'h80, MODE_ASR,  4'd15, 1'b0, 1'b0, 8'hFF};
    vecs[13] = '{8'h12, 3'b111,    4'd0,  1'b1, 1'b1, 8'h12};
    vecs[14] = '{8'h3C, MODE_ROR,  4'd15, 1'b0, 1'b0, 8'h78};
    vecs[15] = '{8'h3C, MODE_LOAD, 4'd9,  1'b0, 1'b0, 8'hC3};

    // Reset state while rst_n is held low.
    #1;
    check("rst_out", {24'd0, Out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ser_lsb", {31'd0, ser_out_lsb}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_out", {24'd0, Out}, 32'd0);

    // Table: load the initial value, then issue the operation back-to-back.
    for (int i = 0; i < 16; i++) begin
      int exp_nb;
      exp_nb = (!is_nop(vecs[i].mode) && vecs[i].mode != MODE_LOAD && vecs[i].amount != 4'd0)
               ? int'(vecs[i].amount) : 0;
      run_cmd(MODE_LOAD, 4'd0, vecs[i].init, 1'b0, 1'b0, 1'b0, vecs[i].init, 0);
      run_cmd(vecs[i].mode, vecs[i].amount, ~vecs[i].init, vecs[i].lsb, vecs[i].msb,
              1'b0, vecs[i].exp, exp_nb);
      check("vec_ser_lsb", {31'd0, ser_out_lsb}, {31'd0, vecs[i].exp[0]});
      check("vec_ser_msb", {31'd0, ser_out_msb}, {31'd0, vecs[i].exp[7]});
    end

    // Step-by-step SHL of A5 with fill 1: unchanged on accept, then 4B, 97, 2F.
    run_cmd(MODE_LOAD, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5, 0);
    exp_q.push_back(8'h2F);
    mode = MODE_SHL; amount = 4'd3; ser_in_lsb = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("step0_out", {24'd0, Out}, 32'h A5);
    check("step0_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("step1_out", {24'd0, Out}, 32'h4B);
    @(negedge clk);
    check("step2_out", {24'd0, Out}, 32'h97);
    check("step2_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("step3_out", {24'd0, Out}, 32'h2F);
    check("step3_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);

    // Start while busy is ignored: ROL 4 of 0F completes as F0 in 4 cycles.
    run_cmd(MODE_LOAD, 4'd0, 8'h0F, 1'b0, 1'b0, 1'b0, 8'h0F, 0);
    begin
      int nb = 0;
      int cyc = 0;
      exp_q.push_back(8'hF0);
      mode = MODE_ROL; amount = 4'd4; start = 1'b1;
      @(negedge clk);
      if (busy === 1'b1) nb++;
      mode = MODE_SHR; amount = 4'd1; ser_in_msb = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (done !== 1'b1 && cyc < 40) begin
        if (busy === 1'b1) nb++;
        @(negedge clk);
        cyc++;
      end
      check("ignored_start_busy", nb, 4);
      @(negedge clk);
      check("ignored_start_idle", {31'd0, busy}, 32'd0);
    end

    // Abort after two SHR shifts of 80: holds 20, no done.
    ser_in_msb = 1'b0;
    run_cmd(MODE_LOAD, 4'd0, 8'h80, 1'b0, 1'b0, 1'b0, 8'h80, 0);
    mode = MODE_SHR; amount = 4'd6; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    check("abort_shift1", {24'd0, Out}, 32'h40);
    @(negedge clk);
    check("abort_shift2", {24'd0, Out}, 32'h20);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_out", {24'd0, Out}, 32'h20);
    repeat (3) @(negedge clk);
    check("abort_hold", {24'd0, Out}, 32'h20);

    // Abort on the final (cnt=1) edge beats the shift.
    run_cmd(MODE_LOAD, 4'd0, 8'h01, 1'b0, 1'b0, 1'b0, 8'h01, 0);
    mode = MODE_SHL; amount = 4'd1; ser_in_lsb = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort_last_out", {24'd0, Out}, 32'h01);
    check("abort_last_done", {31'd0, done}, 32'd0);
    check("abort_last_busy", {31'd0, busy}, 32'd0);

    // Abort alone in IDLE does nothing; abort with start lets start win.
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort_idle_out", {24'd0, Out}, 32'h01);
    check("abort_idle_done", {31'd0, done}, 32'd0);
    run_cmd(MODE_SHL, 4'd2, 8'h00, 1'b0, 1'b0, 1'b1, 8'h04, 2);

    // Explicit back-to-back: SHR 2 of 80 then ROL 1 issued on the done cycle.
    run_cmd(MODE_LOAD, 4'd0, 8'h80, 1'b0, 1'b0, 1'b0, 8'h80, 0);
    run_cmd(MODE_SHR, 4'd2, 8'h00, 1'b0, 1'b0, 1'b0, 8'h20, 2);
    run_cmd(MODE_ROL, 4'd1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h40, 1);

    // Asynchronous reset mid-RUN: takes effect between edges, command lost.
    run_cmd(MODE_LOAD, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5, 0);
    mode = MODE_ROL; amount = 4'd5; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out", {24'd0, Out}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_async_busy", {31'd0, busy}, 32'd0);
    run_cmd(MODE_LOAD, 4'd0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 0);
    run_cmd(MODE_SHL, 4'd1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h79, 1);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
